// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of mem_port_arbiter.
// Requesters raise *_req and hold it (with its address/data) until *_gnt is seen high in the same cycle.
// Each grant is one accepted transfer. Read data comes back later as a single-cycle *_rvalid pulse, in grant order.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_W-1:0]     ls_addr;
    logic [DATA_W-1:0]     ls_wdata;
    logic [DATA_W/8-1:0]   ls_be;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [DATA_W-1:0]     ls_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  stall_fetch;
    logic                  stall_mem;

    // Pipeline and memory side: drives requests and read data.
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be, stall_fetch, stall_mem
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be, stall_fetch, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and load/store, with starvation guard and read-return tag pipeline.
// Optional performance counters are enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int LOAD_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    mem_port_arbiter_if.slave                 bus,
    output logic [0:0]                        dbg_state,
    output logic [$clog2(STARVE_LIMIT+1)-1:0] dbg_starve_cnt
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]                       perf_conflict_cnt,
    output logic [31:0]                       perf_override_cnt
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    localparam logic [0:0] PRIO_LS = 1'b0;
    localparam logic [0:0] PRIO_IF = 1'b1;

    logic [0:0]              state;
    logic [0:0]              state_nxt;
    logic [SW-1:0]           starve_cnt;
    logic [SW-1:0]           starve_nxt;
    logic                    if_wins;
    logic                    if_gnt;
    logic                    ls_gnt;
    logic                    rd_issue;

    logic                    mem_we_c;
    logic [ADDR_W-1:0]       mem_addr_c;
    logic [DATA_W-1:0]       mem_wdata_c;
    logic [DATA_W/8-1:0]     mem_be_c;

    logic [LOAD_LATENCY-1:0] tag_v;
    logic [LOAD_LATENCY-1:0] tag_if;

    // A saturated starvation count hands IF the win in the same cycle, before the state register catches up.
    assign if_wins = (state == PRIO_IF) || (starve_cnt == STARVE_MAX);
    assign if_gnt  = rstn & bus.if_req & (~bus.ls_req | if_wins);
    assign ls_gnt  = rstn & bus.ls_req & ~if_gnt;

    always_comb begin
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        mem_be_c    = '0;
        if (if_gnt) begin
            mem_addr_c = bus.if_addr;
            mem_be_c   = '1;
        end else if (ls_gnt) begin
            mem_we_c    = bus.ls_we;
            mem_addr_c  = bus.ls_addr;
            mem_wdata_c = bus.ls_wdata;
            mem_be_c    = bus.ls_be;
        end
    end

    always_comb begin
        state_nxt = state;
        if (if_gnt) begin
            state_nxt = PRIO_LS;
        end else if ((state == PRIO_LS) && (starve_cnt == STARVE_MAX)) begin
            state_nxt = PRIO_IF;
        end
        starve_nxt = '0;
        if (bus.if_req && !if_gnt) begin
            starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + SW'(1);
        end
    end

    assign rd_issue = (if_gnt | ls_gnt) & ~mem_we_c;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= PRIO_LS;
            starve_cnt <= '0;
            tag_v      <= '0;
            tag_if     <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            for (int i = LOAD_LATENCY - 1; i > 0; i--) begin
                tag_v[i]  <= tag_v[i-1];
                tag_if[i] <= tag_if[i-1];
            end
            tag_v[0]  <= rd_issue;
            tag_if[0] <= if_gnt;
        end
    end

    assign bus.if_gnt      = if_gnt;
    assign bus.ls_gnt      = ls_gnt;
    assign bus.mem_en      = if_gnt | ls_gnt;
    assign bus.mem_we      = mem_we_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wdata   = mem_wdata_c;
    assign bus.mem_be      = mem_be_c;
    assign bus.stall_fetch = bus.if_req & ~if_gnt;
    assign bus.stall_mem   = bus.ls_req & ~ls_gnt;

    // Both read data buses mirror the memory; only the owner's rvalid qualifies them.
    assign bus.if_rvalid = rstn & tag_v[LOAD_LATENCY-1] & tag_if[LOAD_LATENCY-1];
    assign bus.ls_rvalid = rstn & tag_v[LOAD_LATENCY-1] & ~tag_if[LOAD_LATENCY-1];
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.ls_rdata  = bus.mem_rdata;

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_conflict_cnt <= '0;
            perf_override_cnt <= '0;
        end else begin
            if (bus.if_req && bus.ls_req && (perf_conflict_cnt != '1)) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            // IF granted while LS is also asking can only happen through IF priority.
            if (if_gnt && bus.ls_req && (perf_override_cnt != '1)) begin
                perf_override_cnt <= perf_override_cnt + 32'd1;
            end
        end
    end
`endif
endmodule
